uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit write port (w_data/w_valid/w_ready) among NUM_REQ independent byte-stream requesters.
- Arbitrates round-robin at packet granularity. A grant is held from a requester's first byte through the byte flagged last, so packets never interleave on the serial line.
- Sits between on-chip producers (debug console, status reporter, etc.) and the UART TX FIFO input.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- MAX_BURST, 0: forced grant release after this many payload bytes without last; 0 = unlimited; legal 0..255.

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous, active-high reset
- req_data  input  NUM_REQ*8  byte from requester i on bits [8i+7:8i]
- req_valid  input  NUM_REQ  requester i has a byte
- req_last  input  NUM_REQ  byte is the final byte of the packet
- req_ready  output  NUM_REQ  byte from requester i accepted this cycle when req_valid[i]&req_ready[i]
- w_data  output  8  byte to UART TX FIFO
- w_valid  output  1  w_data valid
- w_ready  input  1  UART TX FIFO not full
- grant_id  output  clog2(NUM_REQ), minimum 1  currently/last granted requester
- busy  output  1  a packet is in progress (state != IDLE) or w_valid is high

Behaviour:
- Reset values: req_ready=0, w_valid=0, w_data=0, grant_id=0, busy=0, state=IDLE, rr pointer=0, burst count=0. Reset mid-packet drops the held output byte and the grant immediately; there is no partial-packet recovery.
- Output stage: one registered byte (w_data/w_valid).
  - Stage loads when it is empty or being drained (out_free = !w_valid | w_ready).
  - w_valid stays high and w_data stays stable until w_valid&w_ready.
  - Zero bubble: with w_ready held high, one byte per cycle.
- States:
  - IDLE: pick a winner among the set req_valid bits, searching upward from rr pointer and wrapping (pointer, pointer+1, ... mod NUM_REQ). The winner registers into grant_id and state goes to DATA (or HEADER when the feature is enabled). No byte is accepted in the arbitration cycle, so latency from req_valid to first req_ready is 1 cycle.
  - HEADER (feature only): when out_free, load w_data = {4'hA, 1'b0, grant_id zero-extended to 3 bits}, then go to DATA.
  - DATA: req_ready[grant_id] = out_free. All other req_ready bits are 0. On handshake, the byte loads into the output stage and the burst count increments.
    - If req_last is set, or MAX_BURST!=0 and count==MAX_BURST-1: go to IDLE, rr pointer = grant_id+1 mod NUM_REQ, count=0.
- req_ready is combinational from state, grant_id, w_valid and w_ready. req_data/req_valid do not combinationally reach w_data/w_valid.
- Granted requester deasserting req_valid mid-packet: grant held, arbiter waits indefinitely unless the MAX_BURST release fires.
- A requester whose packet is cut by MAX_BURST loses the grant. Its remaining bytes are arbitrated as a new packet.
- A requester asserting req_valid in the IDLE cycle alongside others: lowest index at or above the pointer wins. Losers keep valid with ready=0 (no drop).
- Single-byte packet (last on first byte): IDLE→DATA→IDLE, 2 cycles per packet of arbiter overhead.
- busy drops only after the final byte has been accepted by w_ready.

Optional Feature:
- Macro UART_TX_ARB_HEADER_EN.
- Defined: HEADER state is present; every packet is prefixed by one byte 0xA0|grant_id. The header does not count toward MAX_BURST. A packet cut by MAX_BURST gets a new header on re-grant.
- Undefined: HEADER state and its logic are absent; IDLE goes directly to DATA; the output carries payload bytes only.

Test Plan:
- Single requester 0 sends 0x11,0x22,0x33(last), w_ready=1 → w_data sequence 0x11,0x22,0x33 on consecutive cycles; first req_ready 1 cycle after req_valid; grant_id=0; busy low after the last handshake.
- Req 1 and 3 both valid at reset, 2-byte packets each → req1 packet complete first, then req3; no interleave. Then req0 and req1 valid again → req3's release sets the pointer to 0, so req0 wins.
- w_ready toggled 1,0,0,1 during a packet → w_data held stable while w_ready=0; no byte lost or duplicated; req_ready low while stalled.
- MAX_BURST=2, req2 sends 5 bytes with no last while req0 is waiting → 2 bytes from req2, then req0's packet, then req2 resumes.
- RST asserted mid-packet with w_valid=1 → next cycle w_valid=0, all req_ready=0, busy=0. After release, a new packet from req1 is granted normally.
- With UART_TX_ARB_HEADER_EN: req2 sends 0x55(last) → w_data 0xA2 then 0x55. Without the macro: 0x55 only.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX write port.
// Define UART_TX_ARB_HEADER_EN to prefix each packet with 0xA0|grant_id.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 0,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           w_data,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [GW-1:0]        grant_id,
  output logic                 busy
);

`ifdef UART_TX_ARB_HEADER_EN
  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

  state_t        state_q, state_d;
  logic [GW-1:0] rr_q;
  logic [7:0]    cnt_q;
  logic [GW-1:0] win;
  logic          found;
  logic          out_free;
  logic          burst_end;
  logic          ld;
  logic [7:0]    ld_byte;
  logic          rel;
  logic [GW-1:0] nxt_ptr;
  int            idx;

  assign out_free  = !w_valid || w_ready;
  assign burst_end = (MAX_BURST != 0) &&
                     (cnt_q == 8'(MAX_BURST - 1));
  assign nxt_ptr   = (grant_id == GW'(NUM_REQ - 1)) ?
                     '0 : grant_id + GW'(1);
  assign busy      = (state_q != IDLE) || w_valid;

  // Upward search from the pointer with wrap-around.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    ld        = 1'b0;
    ld_byte   = '0;
    rel       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
`ifdef UART_TX_ARB_HEADER_EN
          state_d = HEADER;
`else
          state_d = DATA;
`endif
        end
      end
`ifdef UART_TX_ARB_HEADER_EN
      HEADER: begin
        if (out_free) begin
          ld      = 1'b1;
          ld_byte = {4'hA, 1'b0, 3'(grant_id)};
          state_d = DATA;
        end
      end
`endif
      DATA: begin
        req_ready[grant_id] = out_free;
        if (req_valid[grant_id] && out_free) begin
          ld      = 1'b1;
          ld_byte = req_data[8*int'(grant_id) +: 8];
          if (req_last[grant_id] || burst_end) begin
            rel     = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      grant_id <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
      w_data   <= '0;
      w_valid  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found)
        grant_id <= win;
      if (ld) begin
        w_data  <= ld_byte;
        w_valid <= 1'b1;
      end else if (w_ready) begin
        w_valid <= 1'b0;
      end
      // Header loads never advance the burst count.
      if (rel) begin
        rr_q  <= nxt_ptr;
        cnt_q <= '0;
      end else if (ld && state_q == DATA) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

endmodule
